// File: rtl/fp32_div_sqrt_iter_unit_if.sv
// Issue/execute handshake and operand bus for the iterative FP32 divide/sqrt unit.
// The free strobe is named release_en because `release` is a reserved word.
interface fp32_div_sqrt_iter_unit_if;
   logic        acquire;
   logic        req;
   logic        is_divide;
   logic [31:0] data_in_a;
   logic [31:0] data_in_b;
   logic [2:0]  rm;
   logic        release_en;
   logic        flush;
   logic        reserved;
   logic        busy;
   logic        finished;
   logic [31:0] data_out;
   logic [4:0]  fflags_out;

   modport master (
      output acquire, req, is_divide, data_in_a, data_in_b, rm, release_en, flush,
      input  reserved, busy, finished, data_out, fflags_out
   );

   modport slave (
      input  acquire, req, is_divide, data_in_a, data_in_b, rm, release_en, flush,
      output reserved, busy, finished, data_out, fflags_out
   );
endinterface

// File: rtl/fp32_div_sqrt_iter_unit.sv
// Iterative binary32 divide / square root: radix-2 restoring recurrence, 26 quotient
// bits, one rounding cycle, result held until released. DAZ on inputs, FTZ on outputs.
module fp32_div_sqrt_iter_unit (
   input  logic                         clk,
   input  logic                         rst_n,
   fp32_div_sqrt_iter_unit_if.slave     bus
);
   localparam int unsigned SIG_W = 24;
   localparam int unsigned Q_W   = 26;
   localparam int unsigned REM_W = 30;
   localparam int unsigned RAD_W = 52;
   localparam int unsigned EXP_W = 10;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned ITERS = 26;
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   typedef enum logic [2:0] {FREE, RESERVED, ITER, ROUND, DONE} state_t;

   state_t                  state;
   logic                    reserved_q, busy_q, finished_q;
   logic [31:0]             data_q;
   logic [4:0]              fflags_q;
   logic                    is_div_q, sign_q;
   logic [2:0]              rm_q;
   logic signed [EXP_W-1:0] exp_q;
   logic [Q_W-1:0]          quo_q;
   logic [REM_W-1:0]        rem_q;
   logic [SIG_W-1:0]        div_q;
   logic [RAD_W-1:0]        rad_q;
   logic [CNT_W-1:0]        cnt_q;

   // Operand field decode, DAZ applied through the zero tests
   logic        sa, sb;
   logic [7:0]  ea, eb;
   logic [22:0] ma, mb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   assign {sa, ea, ma} = bus.data_in_a;
   assign {sb, eb, mb} = bus.data_in_b;
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);
   assign a_inf  = (ea == 8'hFF) && (ma == 23'h0);
   assign b_inf  = (eb == 8'hFF) && (mb == 23'h0);
   assign a_nan  = (ea == 8'hFF) && (ma != 23'h0);
   assign b_nan  = (eb == 8'hFF) && (mb != 23'h0);
   assign a_snan = a_nan && !ma[22];
   assign b_snan = b_nan && !mb[22];

   logic        special_c;
   logic [31:0] spec_res_c;
   logic [4:0]  spec_flags_c;
   logic        sq_c;
   assign sq_c = sa ^ sb;

   // Special-case resolution in the req cycle
   always_comb begin
      special_c    = 1'b0;
      spec_res_c   = 32'h0;
      spec_flags_c = 5'h0;
      if (bus.is_divide) begin
         if (a_nan || b_nan) begin
            special_c = 1'b1; spec_res_c = QNAN; spec_flags_c = {a_snan | b_snan, 4'b0000};
         end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            special_c = 1'b1; spec_res_c = QNAN; spec_flags_c = 5'b10000;
         end else if (a_inf) begin
            special_c = 1'b1; spec_res_c = {sq_c, 8'hFF, 23'h0};
         end else if (b_inf) begin
            special_c = 1'b1; spec_res_c = {sq_c, 31'h0};
         end else if (b_zero) begin
            special_c = 1'b1; spec_res_c = {sq_c, 8'hFF, 23'h0}; spec_flags_c = 5'b01000;
         end else if (a_zero) begin
            special_c = 1'b1; spec_res_c = {sq_c, 31'h0};
         end
      end else begin
         if (a_nan) begin
            special_c = 1'b1; spec_res_c = QNAN; spec_flags_c = {a_snan, 4'b0000};
         end else if (a_zero) begin
            special_c = 1'b1; spec_res_c = {sa, 31'h0};
         end else if (sa) begin
            special_c = 1'b1; spec_res_c = QNAN; spec_flags_c = 5'b10000;
         end else if (a_inf) begin
            special_c = 1'b1; spec_res_c = {1'b0, 8'hFF, 23'h0};
         end
      end
   end

   logic signed [EXP_W-1:0] e_unb_c, div_exp_c, sqrt_exp_c;
   logic [SIG_W-1:0]        sig_a_c;
   assign e_unb_c    = $signed({2'b00, ea}) - 10'sd127;
   assign div_exp_c  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
   assign sqrt_exp_c = (e_unb_c >>> 1) + 10'sd127;
   assign sig_a_c    = {1'b1, ma};

   // One recurrence step: restoring divide, or restoring sqrt consuming two radicand bits
   logic [REM_W-1:0] div_ext_c, r2_c, trial_c, rem_n_c;
   logic             ge_c;
   always_comb begin
      div_ext_c = REM_W'(div_q);
      r2_c      = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
      trial_c   = REM_W'({quo_q, 2'b01});
      if (is_div_q) begin
         ge_c    = (rem_q >= div_ext_c);
         rem_n_c = ge_c ? ((rem_q - div_ext_c) << 1) : (rem_q << 1);
      end else begin
         ge_c    = (r2_c >= trial_c);
         rem_n_c = ge_c ? (r2_c - trial_c) : r2_c;
      end
   end

   // Normalise, round per rm, then clamp to overflow / flush-to-zero
   logic [SIG_W-1:0]        mant_c;
   logic [SIG_W:0]          mant_r_c;
   logic [22:0]             frac_c;
   logic                    g_c, s_c, inexact_c, up_c, inf_ok_c;
   logic signed [EXP_W-1:0] e_n_c, e_r_c;
   logic [31:0]             rnd_res_c;
   logic [4:0]              rnd_flags_c;
   always_comb begin
      if (quo_q[Q_W-1]) begin
         mant_c = quo_q[Q_W-1:2]; g_c = quo_q[1]; s_c = quo_q[0] | (|rem_q); e_n_c = exp_q;
      end else begin
         mant_c = quo_q[Q_W-2:1]; g_c = quo_q[0]; s_c = |rem_q; e_n_c = exp_q - 10'sd1;
      end
      inexact_c = g_c | s_c;
      case (rm_q)
         3'd1:    up_c = 1'b0;
         3'd2:    up_c = sign_q & inexact_c;
         3'd3:    up_c = ~sign_q & inexact_c;
         3'd4:    up_c = g_c;
         default: up_c = g_c & (s_c | mant_c[0]);
      endcase
      mant_r_c = {1'b0, mant_c} + (SIG_W+1)'(up_c);
      e_r_c    = e_n_c + (mant_r_c[SIG_W] ? 10'sd1 : 10'sd0);
      frac_c   = mant_r_c[SIG_W] ? mant_r_c[23:1] : mant_r_c[22:0];
      inf_ok_c = (rm_q == 3'd0) || (rm_q == 3'd4) ||
                 ((rm_q == 3'd3) && !sign_q) || ((rm_q == 3'd2) && sign_q);
      if (e_r_c >= 10'sd255) begin
         rnd_res_c   = inf_ok_c ? {sign_q, 8'hFF, 23'h0} : {sign_q, 31'h7F7F_FFFF};
         rnd_flags_c = 5'b00101;
      end else if (e_r_c <= 10'sd0) begin
         rnd_res_c   = {sign_q, 31'h0};
         rnd_flags_c = 5'b00011;
      end else begin
         rnd_res_c   = {sign_q, e_r_c[7:0], frac_c};
         rnd_flags_c = {4'b0000, inexact_c};
      end
   end

   // Control FSM with registered status and result outputs; flush overrides everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FREE;
         reserved_q <= 1'b0;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
         data_q     <= 32'h0;
         fflags_q   <= 5'h0;
         is_div_q   <= 1'b0;
         sign_q     <= 1'b0;
         rm_q       <= 3'd0;
         exp_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         div_q      <= '0;
         rad_q      <= '0;
         cnt_q      <= '0;
      end else if (bus.flush) begin
         state      <= FREE;
         reserved_q <= 1'b0;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
         data_q     <= 32'h0;
         fflags_q   <= 5'h0;
      end else begin
         case (state)
            FREE: if (bus.acquire) begin
               state      <= RESERVED;
               reserved_q <= 1'b1;
            end
            RESERVED: if (bus.req) begin
               if (special_c) begin
                  state      <= DONE;
                  finished_q <= 1'b1;
                  data_q     <= spec_res_c;
                  fflags_q   <= spec_flags_c;
               end else begin
                  state    <= ITER;
                  busy_q   <= 1'b1;
                  is_div_q <= bus.is_divide;
                  sign_q   <= bus.is_divide ? sq_c : 1'b0;
                  rm_q     <= (bus.rm > 3'd4) ? 3'd0 : bus.rm;
                  quo_q    <= '0;
                  cnt_q    <= '0;
                  div_q    <= {1'b1, mb};
                  if (bus.is_divide) begin
                     exp_q <= div_exp_c;
                     rem_q <= REM_W'(sig_a_c);
                  end else begin
                     exp_q <= sqrt_exp_c;
                     rem_q <= '0;
                     rad_q <= e_unb_c[0] ? {sig_a_c, 28'h0} : {1'b0, sig_a_c, 27'h0};
                  end
               end
            end
            ITER: begin
               rem_q <= rem_n_c;
               quo_q <= {quo_q[Q_W-2:0], ge_c};
               rad_q <= {rad_q[RAD_W-3:0], 2'b00};
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(ITERS - 1)) state <= ROUND;
            end
            ROUND: begin
               state      <= DONE;
               busy_q     <= 1'b0;
               finished_q <= 1'b1;
               data_q     <= rnd_res_c;
               fflags_q   <= rnd_flags_c;
            end
            DONE: if (bus.release_en) begin
               state      <= FREE;
               reserved_q <= 1'b0;
               finished_q <= 1'b0;
               data_q     <= 32'h0;
               fflags_q   <= 5'h0;
            end
            default: state <= FREE;
         endcase
      end
   end

   assign bus.reserved   = reserved_q;
   assign bus.busy       = busy_q;
   assign bus.finished   = finished_q;
   assign bus.data_out   = data_q;
   assign bus.fflags_out = fflags_q;
endmodule

// File: tb/tb_fp32_div_sqrt_iter_unit.sv
// Directed vector bench for fp32_div_sqrt_iter_unit: table of hand-computed results
// plus short sequences for flush, reset, release and ignored-request corners.
module tb_fp32_div_sqrt_iter_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   fp32_div_sqrt_iter_unit_if bus_if ();

   fp32_div_sqrt_iter_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        is_div;
      logic [2:0]  rm;
      logic [31:0] res;
      logic [4:0]  flags;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic is_div, logic [2:0] rm,
                               logic [31:0] res, logic [4:0] flags, int lat);
      vec_t v;
      v.a = a; v.b = b; v.is_div = is_div; v.rm = rm;
      v.res = res; v.flags = flags; v.lat = lat;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Acquire, then issue req; returns one cycle after the req cycle with operands scrambled
   task automatic start_op(string name, vec_t v);
      bus_if.acquire = 1'b1;
      tick();
      bus_if.acquire = 1'b0;
      check({name, " reserved"}, 32'(bus_if.reserved), 32'd1);
      bus_if.req       = 1'b1;
      bus_if.data_in_a = v.a;
      bus_if.data_in_b = v.b;
      bus_if.is_divide = v.is_div;
      bus_if.rm        = v.rm;
      tick();
      bus_if.req       = 1'b0;
      bus_if.data_in_a = 32'hDEAD_BEEF;
      bus_if.data_in_b = 32'h1234_5678;
      bus_if.is_divide = ~v.is_div;
      bus_if.rm        = 3'd1;
   endtask

   task automatic wait_done(string name, output int lat, output int busy_cnt);
      lat = 1;
      busy_cnt = 0;
      while (!bus_if.finished && lat < 100) begin
         if (bus_if.busy) busy_cnt++;
         tick();
         lat++;
      end
      if (!bus_if.finished) begin
         check({name, " timeout finished"}, 32'(bus_if.finished), 32'd1);
         bus_if.flush = 1'b1;
         tick();
         bus_if.flush = 1'b0;
      end
   endtask

   task automatic run_vec(string name, vec_t v);
      int lat, bcnt;
      start_op(name, v);
      wait_done(name, lat, bcnt);
      check({name, " data"}, bus_if.data_out, v.res);
      check({name, " fflags"}, 32'(bus_if.fflags_out), 32'(v.flags));
      check({name, " latency"}, 32'(lat), 32'(v.lat));
      check({name, " busy cycles"}, 32'(bcnt), (v.lat == 1) ? 32'd0 : 32'd27);
      bus_if.release_en = 1'b1;
      tick();
      bus_if.release_en = 1'b0;
      check({name, " freed"}, 32'({bus_if.reserved, bus_if.finished}), 32'd0);
   endtask

   task automatic check_idle(string name);
      check({name, " status"}, 32'({bus_if.reserved, bus_if.busy, bus_if.finished}), 32'd0);
      check({name, " data"}, bus_if.data_out, 32'h0);
      check({name, " fflags"}, 32'(bus_if.fflags_out), 32'd0);
   endtask

   initial begin
      vec_t six_two;
      bus_if.acquire = 1'b0; bus_if.req = 1'b0; bus_if.is_divide = 1'b0;
      bus_if.data_in_a = 32'h0; bus_if.data_in_b = 32'h0; bus_if.rm = 3'd0;
      bus_if.release_en = 1'b0; bus_if.flush = 1'b0;

      six_two = mk(32'h40C0_0000, 32'h4000_0000, 1'b1, 3'd0, 32'h4040_0000, 5'h00, 28);
      vecs.push_back(six_two);
      vecs.push_back(mk(32'h3F80_0000, 32'h4040_0000, 1'b1, 3'd0, 32'h3EAA_AAAB, 5'h01, 28));
      vecs.push_back(mk(32'h3F80_0000, 32'h4040_0000, 1'b1, 3'd1, 32'h3EAA_AAAA, 5'h01, 28));
      vecs.push_back(mk(32'h3F80_0000, 32'h4040_0000, 1'b1, 3'd2, 32'h3EAA_AAAA, 5'h01, 28));
      vecs.push_back(mk(32'h3F80_0000, 32'h4040_0000, 1'b1, 3'd3, 32'h3EAA_AAAB, 5'h01, 28));
      vecs.push_back(mk(32'h3F80_0000, 32'h4040_0000, 1'b1, 3'd4, 32'h3EAA_AAAB, 5'h01, 28));
      vecs.push_back(mk(32'h3F80_0000, 32'h4040_0000, 1'b1, 3'd5, 32'h3EAA_AAAB, 5'h01, 28));
      vecs.push_back(mk(32'hBF80_0000, 32'h4040_0000, 1'b1, 3'd2, 32'hBEAA_AAAB, 5'h01, 28));
      vecs.push_back(mk(32'hBF80_0000, 32'h4040_0000, 1'b1, 3'd3, 32'hBEAA_AAAA, 5'h01, 28));
      vecs.push_back(mk(32'hC0C0_0000, 32'h4000_0000, 1'b1, 3'd0, 32'hC040_0000, 5'h00, 28));
      vecs.push_back(mk(32'h4000_0000, 32'h0000_0000, 1'b0, 3'd0, 32'h3FB5_04F3, 5'h01, 28));
      vecs.push_back(mk(32'h4080_0000, 32'h0000_0000, 1'b0, 3'd0, 32'h4000_0000, 5'h00, 28));
      vecs.push_back(mk(32'hBF80_0000, 32'h0000_0000, 1'b0, 3'd0, 32'h7FC0_0000, 5'h10, 1));
      vecs.push_back(mk(32'h8000_0000, 32'h0000_0000, 1'b0, 3'd0, 32'h8000_0000, 5'h00, 1));
      vecs.push_back(mk(32'h7F80_0000, 32'h0000_0000, 1'b0, 3'd0, 32'h7F80_0000, 5'h00, 1));
      vecs.push_back(mk(32'h0000_0001, 32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000, 5'h00, 1));
      vecs.push_back(mk(32'h3F80_0000, 32'h0000_0000, 1'b1, 3'd0, 32'h7F80_0000, 5'h08, 1));
      vecs.push_back(mk(32'h7F00_0000, 32'h3E80_0000, 1'b1, 3'd0, 32'h7F80_0000, 5'h05, 28));
      vecs.push_back(mk(32'h7F00_0000, 32'h3E80_0000, 1'b1, 3'd1, 32'h7F7F_FFFF, 5'h05, 28));
      vecs.push_back(mk(32'hFF00_0000, 32'h3E80_0000, 1'b1, 3'd2, 32'hFF80_0000, 5'h05, 28));
      vecs.push_back(mk(32'hFF00_0000, 32'h3E80_0000, 1'b1, 3'd3, 32'hFF7F_FFFF, 5'h05, 28));
      vecs.push_back(mk(32'h0080_0000, 32'h7F00_0000, 1'b1, 3'd0, 32'h0000_0000, 5'h03, 28));
      vecs.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b1, 3'd0, 32'h7FC0_0000, 5'h10, 1));
      vecs.push_back(mk(32'h7F80_0001, 32'h3F80_0000, 1'b1, 3'd0, 32'h7FC0_0000, 5'h10, 1));
      vecs.push_back(mk(32'h7FC0_0000, 32'h3F80_0000, 1'b1, 3'd0, 32'h7FC0_0000, 5'h00, 1));
      vecs.push_back(mk(32'h3F80_0000, 32'h7F80_0000, 1'b1, 3'd0, 32'h0000_0000, 5'h00, 1));
      vecs.push_back(mk(32'hC000_0000, 32'h0000_0000, 1'b1, 3'd0, 32'hFF80_0000, 5'h08, 1));

      repeat (3) tick();
      check_idle("reset");
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

      // req while FREE is ignored
      bus_if.req = 1'b1; bus_if.is_divide = 1'b1;
      bus_if.data_in_a = 32'h40C0_0000; bus_if.data_in_b = 32'h4000_0000;
      tick();
      bus_if.req = 1'b0;
      tick();
      check_idle("req_free");

      // flush 10 cycles after req, then a clean 6/2
      start_op("flush", six_two);
      repeat (9) tick();
      check("flush busy_before", 32'(bus_if.busy), 32'd1);
      bus_if.flush = 1'b1;
      tick();
      bus_if.flush = 1'b0;
      check_idle("flush");
      run_vec("after_flush", six_two);

      // result held in DONE, then flush+release together frees the unit
      begin
         int lat, bcnt;
         start_op("hold", six_two);
         wait_done("hold", lat, bcnt);
         repeat (3) tick();
         check("hold data", bus_if.data_out, 32'h4040_0000);
         check("hold finished", 32'(bus_if.finished), 32'd1);
         bus_if.flush = 1'b1; bus_if.release_en = 1'b1;
         tick();
         bus_if.flush = 1'b0; bus_if.release_en = 1'b0;
         check_idle("flush_release");
      end

      // asynchronous reset 5 cycles after req
      start_op("rst", six_two);
      repeat (4) tick();
      check("rst busy_before", 32'(bus_if.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_idle("async_rst");
      tick();
      rst_n = 1'b1;
      tick();
      run_vec("after_rst", six_two);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
